mem_access_unit: RTL and testbench

//   Load/store front end sitting directly upstream of the 4 KB data memory.

---
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front end for the 4 KB data memory: alignment check, byte-enable
// generation, one-cycle memory access and load-data extension.
module mem_access_unit #(
    parameter int Width     = 32,
    parameter int AddrWidth = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [1:0]           size_i,
    input  logic                 sign_ext_i,
    input  logic [31:0]          addr_i,
    input  logic [Width-1:0]     wdata_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic                 addr_err_o,
    output logic [Width-1:0]     rdata_o,
    output logic [AddrWidth-1:0] dm_addr_o,
    output logic [3:0]           dm_be_o,
    output logic [Width-1:0]     dm_din_o,
    output logic                 dm_wr_o,
    input  logic [Width-1:0]     dm_dout_i,
    output logic [1:0]           dbg_state_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    // Handshake: a request transfers on a posedge where req_i and ready_o are
    // both high; requests presented while ready_o is low are dropped.
    logic [1:0]           state_q, state_d;
    logic                 we_q;
    logic [1:0]           size_q;
    logic                 sign_q;
    logic [1:0]           off_q;
    logic [AddrWidth-1:0] dm_addr_q;
    logic [Width-1:0]     dm_din_q;
    logic [3:0]           dm_be_q;
    logic [Width-1:0]     rdata_q, rdata_d;

    logic                 align_err;
    logic [3:0]           be_d;
    logic [Width-1:0]     lane_shift;
    logic [Width-1:0]     load_ext;

    always_comb begin
        align_err = 1'b0;
        be_d      = 4'b0000;
        case (size_i)
            2'b00: be_d = 4'b0001 << addr_i[1:0];
            2'b01: begin
                align_err = addr_i[0];
                be_d      = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                align_err = |addr_i[1:0];
                be_d      = 4'b1111;
            end
            default: align_err = 1'b1;
        endcase
        // Rejected requests never present an enable pattern to the memory.
        if (align_err) begin
            be_d = 4'b0000;
        end
    end

    always_comb begin
        lane_shift = dm_dout_i >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = {{(Width-8){sign_q & lane_shift[7]}}, lane_shift[7:0]};
            2'b01:   load_ext = {{(Width-16){sign_q & lane_shift[15]}}, lane_shift[15:0]};
            default: load_ext = dm_dout_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    state_d = align_err ? S_ERR : S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                if (!we_q) begin
                    rdata_d = load_ext;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            sign_q    <= 1'b0;
            off_q     <= 2'b00;
            dm_addr_q <= '0;
            dm_din_q  <= '0;
            dm_be_q   <= 4'b0000;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (state_q == S_IDLE && req_i) begin
                we_q      <= we_i;
                size_q    <= size_i;
                sign_q    <= sign_ext_i;
                off_q     <= addr_i[1:0];
                dm_addr_q <= addr_i[AddrWidth+1:2];
                dm_din_q  <= wdata_i;
                dm_be_q   <= be_d;
            end
        end
    end

    // Strobe is decoded from state so an asynchronous reset drops it at once.
    assign ready_o     = (state_q == S_IDLE);
    assign done_o      = (state_q == S_DONE) || (state_q == S_ERR);
    assign addr_err_o  = (state_q == S_ERR);
    assign dm_wr_o     = (state_q == S_ACCESS) && we_q;
    assign rdata_o     = rdata_q;
    assign dm_addr_o   = dm_addr_q;
    assign dm_be_o     = dm_be_q;
    assign dm_din_o    = dm_din_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 1024-word data memory.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        addr_err;
    logic [31:0] rdata;
    logic [9:0]  dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_din;
    logic        dm_wr;
    logic [31:0] dm_dout;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:1023];
    int n_vec;
    int n_err;

    mem_access_unit #(.Width(32), .AddrWidth(10)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
        .sign_ext_i(sign_ext), .addr_i(addr), .wdata_i(wdata),
        .ready_o(ready), .done_o(done), .addr_err_o(addr_err), .rdata_o(rdata),
        .dm_addr_o(dm_addr), .dm_be_o(dm_be), .dm_din_o(dm_din), .dm_wr_o(dm_wr),
        .dm_dout_i(dm_dout), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The memory takes right-justified store data and steers it to the enabled lanes.
    assign dm_dout = mem[dm_addr];
    always @(negedge clk) begin : mem_wr
        int lo;
        if (dm_wr) begin
            lo = 0;
            for (int b = 3; b >= 0; b--) if (dm_be[b]) lo = b;
            for (int b = 0; b < 4; b++) begin
                if (dm_be[b]) mem[dm_addr][8*b +: 8] <= dm_din[8*(b-lo) +: 8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request from IDLE; checks accept-cycle outputs, latency, strobe count and result.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err, input logic [3:0] exp_be,
                          input logic [31:0] exp_rd);
        int cyc;
        int wr_cnt;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        check_eq("ready_busy", 32'(ready), 32'd0);
        if (!exp_err) begin
            check_eq("dm_addr", 32'(dm_addr), 32'(a[11:2]));
            check_eq("dm_be", 32'(dm_be), 32'(exp_be));
            check_eq("dm_din", dm_din, d);
        end
        cyc = 1;
        wr_cnt = 0;
        while (!done && cyc < 6) begin
            if (dm_wr) wr_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("latency", 32'(cyc), exp_err ? 32'd1 : 32'd2);
        check_eq("wr_cycles", 32'(wr_cnt), (w && !exp_err) ? 32'd1 : 32'd0);
        check_eq("addr_err", 32'(addr_err), 32'(exp_err));
        check_eq("rdata", rdata, exp_rd);
        @(posedge clk); #1;
        check_eq("ready_idle", 32'(ready), 32'd1);
        check_eq("done_clear", 32'(done), 32'd0);
    endtask

    initial begin : main
        int done_seen;
        int acc, dn, wr;
        logic rdy;
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        #22;
        rst = 1'b0;
        #1;
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(addr_err), 32'd0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_dm_addr", 32'(dm_addr), 32'h0);
        check_eq("rst_dm_be", 32'(dm_be), 32'h0);
        check_eq("rst_dm_din", dm_din, 32'h0);
        check_eq("rst_dm_wr", 32'(dm_wr), 32'd0);

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0);
        check_eq("mem4_sw", mem[4], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF);
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, 1'b0, 4'b1000, 32'hDEADBEEF);
        check_eq("mem4_sb", mem[4], 32'hA5ADBEEF);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 4'b1000, 32'hFFFFFFA5);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 4'b1000, 32'h000000A5);
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 1'b0, 4'b1100, 32'h000000A5);
        check_eq("mem4_sh", mem[4], 32'h8001BEEF);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 4'b1100, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 4'b1100, 32'h00008001);
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 4'b0011, 32'h0000BEEF);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 4'b0010, 32'hFFFFFFBE);

        do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 4'b0000, 32'hFFFFFFBE);
        do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h00001234, 1'b1, 4'b0000, 32'hFFFFFFBE);
        check_eq("mem4_err", mem[4], 32'h8001BEEF);
        do_req(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 1'b1, 4'b0000, 32'hFFFFFFBE);

        // Reset lands inside ACCESS, ahead of the negedge that would write.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h20; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req = 1'b0;
        check_eq("rst_mid_wr_on", 32'(dm_wr), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_mid_wr_off", 32'(dm_wr), 32'd0);
        check_eq("rst_mid_ready", 32'(ready), 32'd1);
        check_eq("rst_mid_done", 32'(done), 32'd0);
        #1 rst = 1'b0;
        done_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check_eq("rst_mid_nodone", 32'(done_seen), 32'd0);
        check_eq("rst_mid_mem8", mem[8], 32'h0);
        check_eq("rst_mid_rdata", rdata, 32'h0);

        // req held for 8 cycles, alternating store/load at word 12.
        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h30; wdata = 32'h5A5A0001;
        acc = 0; dn = 0; wr = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rdy = ready;
            @(posedge clk); #1;
            if (dm_wr) wr++;
            if (done) dn++;
            if (rdy) begin
                acc++;
                we = ~we;
                if (we) wdata = 32'h0BADF00D;
            end
        end
        req = 1'b0;
        check_eq("b2b_accepts", 32'(acc), 32'd3);
        check_eq("b2b_dones", 32'(dn), 32'd3);
        check_eq("b2b_writes", 32'(wr), 32'd2);
        check_eq("b2b_rdata", rdata, 32'h5A5A0001);
        check_eq("b2b_mem12", mem[12], 32'h0BADF00D);
        @(posedge clk); #1;
        check_eq("b2b_idle", 32'(ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
